// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
//   Shared types and helpers for the data-memory responder.
//   - mem_mode_e  : load/store access modes, funct3 encoding
//   - rsp_state_e : responder FSM state encoding (plain constants)
//   - lane_mask() : byte-enable mask for an access size and byte lane
// ----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [2:0] {
        MODE_B  = 3'b000,
        MODE_H  = 3'b001,
        MODE_W  = 3'b010,
        MODE_BU = 3'b100,
        MODE_HU = 3'b101
    } mem_mode_e;

    // State encoding kept as plain vectors so it matches older netlists
    // and waveform decoders that expect the raw 2-bit values.
    typedef logic [1:0] rsp_state_e;
    localparam rsp_state_e ST_IDLE = 2'd0;
    localparam rsp_state_e ST_WAIT = 2'd1;
    localparam rsp_state_e ST_RESP = 2'd2;

    // size: 00 byte, 01 half, others word. lane: addr[1:0].
    // A half always covers the pair of lanes selected by lane[1].
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << {lane[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
//   Load/store request and response channels between the CPU datapath
//   (master) and the data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_we/mode/addr/wdata : request payload
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : response payload
// ----------------------------------------------------------------------------
interface data_mem_responder_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_mode;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_we, req_mode, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_mode, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_array.sv
// ----------------------------------------------------------------------------
// data_mem_array
//   Byte-lane data RAM: one 8-bit array per lane, synchronous write with a
//   per-lane byte enable, combinational word read.
//   clk   : write clock
//   idx   : word index (byte address without the lane bits)
//   be    : per-lane write enable
//   wdata : write word, lane l taken from bits [8l+7:8l]
//   rdata : word at idx
// ----------------------------------------------------------------------------
module data_mem_array #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 17
) (
    input  logic                                       clk,
    input  logic [ADDR_BITS-$clog2(WIDTH/8)-1:0]       idx,
    input  logic [WIDTH/8-1:0]                         be,
    input  logic [WIDTH-1:0]                           wdata,
    output logic [WIDTH-1:0]                           rdata
);
    localparam int LANES = WIDTH / 8;
    localparam int DEPTH = 2 ** (ADDR_BITS - $clog2(LANES));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] mem [DEPTH];

        // NOTE: RAM contents have no reset; a reset would turn the array into
        // flops and the memory is defined to survive reset anyway.
        always_ff @(posedge clk) begin
            if (be[l]) mem[idx] <= wdata[8*l +: 8];
        end

        assign rdata[8*l +: 8] = mem[idx];
    end

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the CPU load/store port. Accepts one request
//   at a time, waits WAIT_CYCLES, performs the access on the transition into
//   RESP and holds the (extended) result until the response is accepted.
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : request/response channels (slave side)
// ----------------------------------------------------------------------------
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADDR_BITS   = 17,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int               CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    rsp_state_e           state;
    logic [CNT_W-1:0]     cnt;
    logic                 lat_we;
    logic [2:0]           lat_mode;
    logic [ADDR_BITS-1:0] lat_addr;
    logic [WIDTH-1:0]     lat_wdata;
    logic [WIDTH-1:0]     rdata_q;
    logic                 err_q;

    logic                 accept;
    logic                 commit;
    logic                 acc_we;
    logic [2:0]           acc_mode;
    logic [ADDR_BITS-1:0] acc_addr;
    logic [WIDTH-1:0]     acc_wdata;
    logic                 acc_err;
    logic [WIDTH-1:0]     mem_rdata;
    logic [WIDTH-1:0]     lane_word;
    logic [WIDTH-1:0]     load_val;
    logic [WIDTH-1:0]     result;
    logic [WIDTH-1:0]     store_word;
    logic [WIDTH/8-1:0]   store_be;
    logic                 unused_addr_bits;

    // Upper address bits alias onto the decoded range.
    assign unused_addr_bits = ^bus.req_addr[WIDTH-1:ADDR_BITS];

    // Gated by rst so req_ready is low for the whole reset pulse.
    assign bus.req_ready = (state == ST_IDLE) && rst;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    assign accept = bus.req_valid && bus.req_ready;

    // With zero wait cycles the access happens on the accept edge itself, so
    // the live request is used; otherwise the latched copy.
    assign acc_we    = (state == ST_IDLE) ? bus.req_we                   : lat_we;
    assign acc_mode  = (state == ST_IDLE) ? bus.req_mode                 : lat_mode;
    assign acc_addr  = (state == ST_IDLE) ? bus.req_addr[ADDR_BITS-1:0]  : lat_addr;
    assign acc_wdata = (state == ST_IDLE) ? bus.req_wdata                : lat_wdata;

    assign commit = (WAIT_CYCLES == 0) ? accept
                                       : ((state == ST_WAIT) && (cnt == CNT_LAST));

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        acc_err = 1'b0;
        case (acc_mode)
            MODE_B, MODE_BU: acc_err = 1'b0;
            MODE_H, MODE_HU: acc_err = acc_addr[0];
            MODE_W:          acc_err = |acc_addr[1:0];
            default:         acc_err = 1'b1;
        endcase
        if (acc_we && acc_mode[2]) acc_err = 1'b1;
    end

    // Move the addressed lane(s) down to bit 0, then extend.
    assign lane_word = mem_rdata >> {acc_addr[1:0], 3'b000};

    always_comb begin
        load_val = lane_word;
        case (acc_mode)
            MODE_B:  load_val = {{(WIDTH-8){lane_word[7]}},   lane_word[7:0]};
            MODE_BU: load_val = {{(WIDTH-8){1'b0}},           lane_word[7:0]};
            MODE_H:  load_val = {{(WIDTH-16){lane_word[15]}}, lane_word[15:0]};
            MODE_HU: load_val = {{(WIDTH-16){1'b0}},          lane_word[15:0]};
            default: load_val = lane_word;
        endcase
    end

    assign result = (acc_err || acc_we) ? '0 : load_val;

    // Replicate store data across lanes; the byte enable picks the target.
    always_comb begin
        store_word = acc_wdata;
        case (acc_mode[1:0])
            2'b00:   store_word = {(WIDTH/8){acc_wdata[7:0]}};
            2'b01:   store_word = {(WIDTH/16){acc_wdata[15:0]}};
            default: store_word = acc_wdata;
        endcase
    end

    assign store_be = (commit && acc_we && !acc_err) ? lane_mask(acc_mode[1:0], acc_addr[1:0])
                                                     : '0;

    data_mem_array #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .idx   (acc_addr[ADDR_BITS-1:2]),
        .be    (store_be),
        .wdata (store_word),
        .rdata (mem_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_mode  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we    <= bus.req_we;
                        lat_mode  <= bus.req_mode;
                        lat_addr  <= bus.req_addr[ADDR_BITS-1:0];
                        lat_wdata <= bus.req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == CNT_LAST) state <= ST_RESP;
                    else                 cnt   <= cnt + 1'b1;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (commit) begin
                rdata_q <= result;
                err_q   <= acc_err;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Two instances share clock, reset
//   and request payload: dut2 (WAIT_CYCLES=2) and dut0 (WAIT_CYCLES=0).
// ----------------------------------------------------------------------------
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int WIDTH     = 32;
    localparam int ADDR_BITS = 17;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if #(.WIDTH(WIDTH)) bus2 ();
    data_mem_responder_if #(.WIDTH(WIDTH)) bus0 ();

    data_mem_responder #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .WAIT_CYCLES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    data_mem_responder #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    logic        t_we;
    logic [2:0]  t_mode;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic        t_rsp_ready;
    logic        t_valid2;
    logic        t_valid0;

    assign bus2.req_valid = t_valid2;
    assign bus2.req_we    = t_we;
    assign bus2.req_mode  = t_mode;
    assign bus2.req_addr  = t_addr;
    assign bus2.req_wdata = t_wdata;
    assign bus2.rsp_ready = t_rsp_ready;
    assign bus0.req_valid = t_valid0;
    assign bus0.req_we    = t_we;
    assign bus0.req_mode  = t_mode;
    assign bus0.req_addr  = t_addr;
    assign bus0.req_wdata = t_wdata;
    assign bus0.rsp_ready = t_rsp_ready;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        bit          fast;
        logic        we;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic rdy(input bit fast);
        return fast ? bus0.req_ready : bus2.req_ready;
    endfunction

    function automatic logic rv(input bit fast);
        return fast ? bus0.rsp_valid : bus2.rsp_valid;
    endfunction

    function automatic logic [31:0] rd(input bit fast);
        return fast ? bus0.rsp_rdata : bus2.rsp_rdata;
    endfunction

    function automatic logic re(input bit fast);
        return fast ? bus0.rsp_err : bus2.rsp_err;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input bit fast, input logic we,
                                input logic [2:0] mode, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic err);
        vec_t v;
        v.name = name; v.fast = fast; v.we = we; v.mode = mode;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
        vecs.push_back(v);
    endfunction

    // Present a request and return #1 after the edge that accepted it.
    task automatic start_req(input string name, input bit fast, input logic we,
                             input logic [2:0] mode, input logic [31:0] addr,
                             input logic [31:0] wdata);
        int n;
        @(negedge clk);
        t_we = we; t_mode = mode; t_addr = addr; t_wdata = wdata;
        if (fast) t_valid0 = 1'b1;
        else      t_valid2 = 1'b1;
        n = 0;
        while (!rdy(fast) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "/req_ready"}, 32'(rdy(fast)), 32'd1);
        @(posedge clk);
        #1;
        t_valid2 = 1'b0;
        t_valid0 = 1'b0;
    endtask

    // Count cycles after the accept edge until rsp_valid is seen (sampled at negedge).
    task automatic wait_rsp(input string name, input bit fast, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rv(fast) && lat < 20);
        check({name, "/rsp_valid"}, 32'(rv(fast)), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        start_req(v.name, v.fast, v.we, v.mode, v.addr, v.wdata);
        wait_rsp(v.name, v.fast, lat);
        check({v.name, "/latency"}, 32'(lat), v.fast ? 32'd1 : 32'd3);
        check({v.name, "/rdata"},   rd(v.fast), v.rdata);
        check({v.name, "/err"},     32'(re(v.fast)), 32'(v.err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] held;

        t_we = 1'b0; t_mode = '0; t_addr = '0; t_wdata = '0;
        t_valid2 = 1'b0; t_valid0 = 1'b0; t_rsp_ready = 1'b1;

        // Main table: WAIT_CYCLES=2 instance.
        add("st_w_10",    0, 1, MODE_W,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0);
        add("ld_w_10",    0, 0, MODE_W,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
        add("ld_b_13",    0, 0, MODE_B,  32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 0);
        add("ld_bu_13",   0, 0, MODE_BU, 32'h0000_0013, 32'h0,         32'h0000_00DE, 0);
        add("ld_hu_12",   0, 0, MODE_HU, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 0);
        add("ld_h_10",    0, 0, MODE_H,  32'h0000_0010, 32'h0,         32'hFFFF_BEEF, 0);
        add("ld_b_10",    0, 0, MODE_B,  32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 0);
        add("st_h_11",    0, 1, MODE_H,  32'h0000_0011, 32'h0000_1234, 32'h0000_0000, 1);
        add("ld_w_10b",   0, 0, MODE_W,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
        add("ld_m011",    0, 0, 3'b011,  32'h0000_0010, 32'h0,         32'h0000_0000, 1);
        add("st_bu_10",   0, 1, MODE_BU, 32'h0000_0010, 32'h0000_0077, 32'h0000_0000, 1);
        add("ld_w_12",    0, 0, MODE_W,  32'h0000_0012, 32'h0,         32'h0000_0000, 1);
        add("ld_hu_13",   0, 0, MODE_HU, 32'h0000_0013, 32'h0,         32'h0000_0000, 1);
        add("ld_m110",    0, 0, 3'b110,  32'h0000_0010, 32'h0,         32'h0000_0000, 1);
        add("ld_m111",    0, 0, 3'b111,  32'h0000_0010, 32'h0,         32'h0000_0000, 1);
        add("ld_w_10c",   0, 0, MODE_W,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
        add("ld_w_alias", 0, 0, MODE_W,  32'h0002_0010, 32'h0,         32'hDEAD_BEEF, 0);
        add("ld_hu_alias",0, 0, MODE_HU, 32'hFFFE_0012, 32'h0,         32'h0000_DEAD, 0);
        add("st_w_14",    0, 1, MODE_W,  32'h0000_0014, 32'h0000_0000, 32'h0000_0000, 0);
        add("st_h_16",    0, 1, MODE_H,  32'h0000_0016, 32'hA5A5_1234, 32'h0000_0000, 0);
        add("st_b_15",    0, 1, MODE_B,  32'h0000_0015, 32'h0000_007F, 32'h0000_0000, 0);
        add("ld_w_14",    0, 0, MODE_W,  32'h0000_0014, 32'h0,         32'h1234_7F00, 0);
        add("ld_b_15",    0, 0, MODE_B,  32'h0000_0015, 32'h0,         32'h0000_007F, 0);
        add("ld_hu_16",   0, 0, MODE_HU, 32'h0000_0016, 32'h0,         32'h0000_1234, 0);
        // WAIT_CYCLES=0 instance: back-to-back store then loads.
        add("f_st_w_40",  1, 1, MODE_W,  32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0000, 0);
        add("f_ld_w_40",  1, 0, MODE_W,  32'h0000_0040, 32'h0,         32'hCAFE_F00D, 0);
        add("f_ld_h_42",  1, 0, MODE_H,  32'h0000_0042, 32'h0,         32'hFFFF_CAFE, 0);
        add("f_ld_bu_41", 1, 0, MODE_BU, 32'h0000_0041, 32'h0,         32'h0000_00F0, 0);
        add("f_st_h_43",  1, 1, MODE_H,  32'h0000_0043, 32'h0000_BEEF, 32'h0000_0000, 1);
        add("f_st_b_43",  1, 1, MODE_B,  32'h0000_0043, 32'h0000_0011, 32'h0000_0000, 0);
        add("f_ld_w_40b", 1, 0, MODE_W,  32'h0000_0040, 32'h0,         32'h11FE_F00D, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst/req_ready",  32'(bus2.req_ready), 32'd0);
        check("rst/rsp_valid",  32'(bus2.rsp_valid), 32'd0);
        check("rst/rsp_rdata",  bus2.rsp_rdata,      32'd0);
        check("rst/rsp_err",    32'(bus2.rsp_err),   32'd0);
        check("rst/req_ready0", 32'(bus0.req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_release/req_ready", 32'(bus2.req_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Response held while rsp_ready is low; a competing request is ignored.
        t_rsp_ready = 1'b0;
        start_req("hold", 0, 0, MODE_W, 32'h0000_0010, 32'h0);
        wait_rsp("hold", 0, lat);
        check("hold/latency", 32'(lat), 32'd3);
        held = bus2.rsp_rdata;
        check("hold/rdata", held, 32'hDEAD_BEEF);
        t_we = 1'b1; t_mode = MODE_W; t_addr = 32'h0000_0010; t_wdata = 32'h0;
        t_valid2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold/rsp_valid", 32'(bus2.rsp_valid), 32'd1);
            check("hold/rsp_rdata", bus2.rsp_rdata,      32'hDEAD_BEEF);
            check("hold/req_ready", 32'(bus2.req_ready), 32'd0);
        end
        t_valid2 = 1'b0;
        t_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release/rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        check("release/req_ready", 32'(bus2.req_ready), 32'd1);
        run_vec('{"ld_after_hold", 0, 0, MODE_W, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0});

        // Reset in the middle of a store's wait: store dropped, outputs cleared.
        start_req("rst_store", 0, 1, MODE_B, 32'h0000_0010, 32'h0000_0055);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst/rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        check("midrst/rsp_rdata", bus2.rsp_rdata,      32'd0);
        check("midrst/rsp_err",   32'(bus2.rsp_err),   32'd0);
        check("midrst/req_ready", 32'(bus2.req_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_release/req_ready", 32'(bus2.req_ready), 32'd1);
        run_vec('{"ld_b_after_rst",  0, 0, MODE_B,  32'h0000_0010, 32'h0, 32'hFFFF_FFEF, 0});
        run_vec('{"ld_bu_after_rst", 0, 0, MODE_BU, 32'h0000_0010, 32'h0, 32'h0000_00EF, 0});
        run_vec('{"f_ld_after_rst",  1, 0, MODE_W,  32'h0000_0040, 32'h0, 32'h11FE_F00D, 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
